// File: rtl/quiz_pkg.sv
// Shared definitions for the equation-round quiz sequencer.
//   TIME_W  : width of the seconds-left display value
//   state_t : sequencer state encoding
package quiz_pkg;

    localparam int unsigned TIME_W = 7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT,
        S_CHECK,
        S_NEXT,
        S_DONE
    } state_t;

endpackage

// File: rtl/quiz_sequencer_tick_gen.sv
// One-second tick prescaler for the quiz timer.
//   Clock : system clock
//   Reset : asynchronous, active-high
//   clear : forces the count back to 0 and suppresses the tick
//   tick  : one-cycle pulse when the count reaches TICK_DIV-1
module tick_gen #(
    parameter int unsigned TICK_DIV = 50000000
) (
    input  logic Clock,
    input  logic Reset,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            count <= '0;
        end else if (clear || count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tick = !clear && (count == LAST);

endmodule

// File: rtl/quiz_sequencer.sv
// Game-phase controller for the equation round: presents NUM_Q questions,
// collects answers on Go presses, enforces time and try limits, keeps score.
//   Clock, Reset : system clock, asynchronous active-high reset
//   Start        : game enable level
//   Go           : synchronised answer-submit key (level)
//   DataIn       : player answer
//   Expected     : correct answer for question QIdx
//   QIdx         : current question index
//   EqEnable     : question live (LOAD, WAIT, CHECK)
//   NewQ         : pulse, question QIdx loaded
//   Correct      : pulse, answer accepted
//   Wrong        : sticky, some question failed this game
//   TimeLeft     : seconds remaining for current question
//   Score        : questions answered correctly
//   Busy         : not IDLE and not DONE
//   Done         : in DONE
module quiz_sequencer
    import quiz_pkg::*;
#(
    parameter int unsigned NUM_Q     = 3,
    parameter int unsigned TICK_DIV  = 50000000,
    parameter int unsigned Q_TIME    = 20,
    parameter int unsigned MAX_TRIES = 3
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Start,
    input  logic              Go,
    input  logic [7:0]        DataIn,
    input  logic [7:0]        Expected,
    output logic [1:0]        QIdx,
    output logic              EqEnable,
    output logic              NewQ,
    output logic              Correct,
    output logic              Wrong,
    output logic [TIME_W-1:0] TimeLeft,
    output logic [2:0]        Score,
    output logic              Busy,
    output logic              Done
);

    state_t     state;
    state_t     state_d;
    logic       go_q;
    logic       go_rise;
    logic       tick;
    logic       clear;
    logic       ans_ok;
    logic       last_try;
    logic       last_q;
    logic       abort;
    logic [2:0] tries;
    logic [7:0] ans;

    // The prescaler only runs while a question is being answered; a tick
    // landing in CHECK is simply not acted upon.
    assign clear = !(state == S_WAIT || state == S_CHECK);

    tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick (
        .Clock(Clock),
        .Reset(Reset),
        .clear(clear),
        .tick (tick)
    );

    assign go_rise  = Go & ~go_q;
    assign ans_ok   = (ans == Expected);
    assign last_try = ({1'b0, tries} + 4'd1) >= 4'(MAX_TRIES);
    assign last_q   = (QIdx == 2'(NUM_Q - 1));
    assign abort    = !Start && (state inside {S_LOAD, S_WAIT, S_CHECK, S_NEXT});

    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:  if (Start) state_d = S_LOAD;
            S_LOAD:  state_d = S_WAIT;
            S_WAIT: begin
                if (go_rise)
                    state_d = S_CHECK;
                else if (tick && TimeLeft == TIME_W'(1))
                    state_d = S_NEXT;
            end
            S_CHECK: state_d = (ans_ok || last_try) ? S_NEXT : S_WAIT;
            S_NEXT:  state_d = last_q ? S_DONE : S_LOAD;
            S_DONE:  if (!Start) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (abort)
            state_d = S_IDLE;
    end

    // Status flags are decoded from the next state so they line up with
    // the state register rather than lagging it by a cycle.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state    <= S_IDLE;
            go_q     <= 1'b1;
            QIdx     <= '0;
            TimeLeft <= '0;
            Score    <= '0;
            Wrong    <= 1'b0;
            tries    <= '0;
            ans      <= '0;
            NewQ     <= 1'b0;
            Correct  <= 1'b0;
            EqEnable <= 1'b0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
        end else begin
            state    <= state_d;
            go_q     <= Go;
            NewQ     <= (state_d == S_LOAD);
            EqEnable <= (state_d inside {S_LOAD, S_WAIT, S_CHECK});
            Busy     <= !(state_d inside {S_IDLE, S_DONE});
            Done     <= (state_d == S_DONE);
            Correct  <= 1'b0;

            if (abort) begin
                TimeLeft <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (Start) begin
                            Score <= '0;
                            Wrong <= 1'b0;
                            QIdx  <= '0;
                        end
                    end
                    S_LOAD: begin
                        TimeLeft <= TIME_W'(Q_TIME);
                        tries    <= '0;
                    end
                    S_WAIT: begin
                        // An answer beats a simultaneous tick.
                        if (go_rise) begin
                            ans <= DataIn;
                        end else if (tick) begin
                            if (TimeLeft == TIME_W'(1)) begin
                                TimeLeft <= '0;
                                Wrong    <= 1'b1;
                            end else begin
                                TimeLeft <= TimeLeft - 1'b1;
                            end
                        end
                    end
                    S_CHECK: begin
                        if (ans_ok) begin
                            Correct <= 1'b1;
                            if (Score < 3'(NUM_Q))
                                Score <= Score + 3'd1;
                        end else if (last_try) begin
                            Wrong <= 1'b1;
                        end else begin
                            tries <= tries + 3'd1;
                        end
                    end
                    S_NEXT: begin
                        if (!last_q)
                            QIdx <= QIdx + 2'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_quiz_sequencer.sv
// Directed bench for quiz_sequencer with TICK_DIV=4, Q_TIME=3,
// MAX_TRIES=2, NUM_Q=3.
module tb_quiz_sequencer;

    logic       Clock    = 1'b0;
    logic       Reset    = 1'b1;
    logic       Start    = 1'b0;
    logic       Go       = 1'b0;
    logic [7:0] DataIn   = 8'd0;
    logic [7:0] Expected = 8'd12;
    logic [1:0] QIdx;
    logic       EqEnable;
    logic       NewQ;
    logic       Correct;
    logic       Wrong;
    logic [6:0] TimeLeft;
    logic [2:0] Score;
    logic       Busy;
    logic       Done;

    int total = 0;
    int bad   = 0;
    int ncorr;

    always #5 Clock = ~Clock;

    quiz_sequencer #(
        .NUM_Q    (3),
        .TICK_DIV (4),
        .Q_TIME   (3),
        .MAX_TRIES(2)
    ) dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .Start   (Start),
        .Go      (Go),
        .DataIn  (DataIn),
        .Expected(Expected),
        .QIdx    (QIdx),
        .EqEnable(EqEnable),
        .NewQ    (NewQ),
        .Correct (Correct),
        .Wrong   (Wrong),
        .TimeLeft(TimeLeft),
        .Score   (Score),
        .Busy    (Busy),
        .Done    (Done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    // Go rise in the current WAIT cycle; returns one cycle later (CHECK).
    task automatic press(input logic [7:0] v);
        DataIn = v;
        Go     = 1'b1;
        step();
        Go     = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_qidx"},  QIdx, 0);
        chk({tag, "_eqen"},  EqEnable, 0);
        chk({tag, "_newq"},  NewQ, 0);
        chk({tag, "_corr"},  Correct, 0);
        chk({tag, "_wrong"}, Wrong, 0);
        chk({tag, "_tl"},    TimeLeft, 0);
        chk({tag, "_score"}, Score, 0);
        chk({tag, "_busy"},  Busy, 0);
        chk({tag, "_done"},  Done, 0);
    endtask

    initial begin
        // reset state
        repeat (3) step();
        chk_all_zero("rst");
        #2 Reset = 1'b0;
        step();
        chk("idle_busy", Busy, 0);

        // all correct
        Start = 1'b1;
        step();
        for (int q = 0; q < 3; q++) begin
            chk("t1_newq", NewQ, 1);
            chk("t1_qidx", QIdx, q);
            chk("t1_busy", Busy, 1);
            step();
            chk("t1_tl", TimeLeft, 3);
            press(8'd12);
            chk("t1_corr_n1", Correct, 0);
            step();
            chk("t1_corr_n2", Correct, 1);
            chk("t1_score", Score, q + 1);
            step();
        end
        chk("t1_done", Done, 1);
        chk("t1_busy_done", Busy, 0);
        chk("t1_eqen_done", EqEnable, 0);
        chk("t1_score_end", Score, 3);
        chk("t1_wrong_end", Wrong, 0);
        chk("t1_qidx_end", QIdx, 2);
        Start = 1'b0;
        step();
        chk("t1_idle_done", Done, 0);
        chk("t1_idle_score", Score, 3);

        // retry then pass on q0
        Start = 1'b1;
        step();
        chk("t2_score_clr", Score, 0);
        chk("t2_qidx_clr", QIdx, 0);
        step();
        press(8'd5);
        step();
        chk("t2_no_corr", Correct, 0);
        chk("t2_back_wait", EqEnable, 1);
        step();
        step();
        chk("t2_tl_tick", TimeLeft, 2);
        press(8'd12);
        step();
        chk("t2_corr", Correct, 1);
        chk("t2_score", Score, 1);
        chk("t2_wrong", Wrong, 0);
        chk("t2_tl_noreload", TimeLeft, 2);

        // try exhaustion on q1
        step();
        chk("t3_newq1", NewQ, 1);
        chk("t3_qidx1", QIdx, 1);
        step();
        press(8'd5);
        step();
        press(8'd5);
        step();
        chk("t3_wrong", Wrong, 1);
        chk("t3_no_corr", Correct, 0);
        chk("t3_score", Score, 1);
        step();
        chk("t3_newq2", NewQ, 1);
        chk("t3_qidx2", QIdx, 2);

        // abort in WAIT
        step();
        chk("ab_busy_wait", Busy, 1);
        Start = 1'b0;
        step();
        chk("ab_busy", Busy, 0);
        chk("ab_eqen", EqEnable, 0);
        chk("ab_tl", TimeLeft, 0);
        chk("ab_score", Score, 1);
        chk("ab_wrong", Wrong, 1);

        // timeout on q0
        Start = 1'b1;
        step();
        chk("to_wrong_clr", Wrong, 0);
        step();
        for (int i = 0; i < 12; i++) begin
            chk("to_tl", TimeLeft, 3 - i / 4);
            step();
        end
        chk("to_tl_zero", TimeLeft, 0);
        chk("to_wrong", Wrong, 1);
        step();
        chk("to_newq", NewQ, 1);
        chk("to_qidx", QIdx, 1);
        step();
        chk("to_tl_reload", TimeLeft, 3);

        // collision on q1, then Go held for 20 cycles
        repeat (3) step();
        DataIn = 8'd12;
        Go     = 1'b1;
        ncorr  = 0;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (Correct)
                ncorr++;
            if (k == 1) begin
                chk("col_tl", TimeLeft, 3);
                chk("col_check", EqEnable, 1);
                chk("col_corr_n1", Correct, 0);
            end
            if (k == 2)
                chk("col_corr_n2", Correct, 1);
        end
        Go = 1'b0;
        chk("held_ncorr", ncorr, 1);
        chk("held_score", Score, 1);
        chk("held_done", Done, 1);
        chk("held_qidx", QIdx, 2);

        // reset mid-CHECK, Go held through release
        Start = 1'b0;
        step();
        Start = 1'b1;
        step();
        step();
        press(8'd12);
        step();
        step();
        step();
        DataIn = 8'd12;
        Go     = 1'b1;
        step();
        chk("rc_score_pre", Score, 1);
        chk("rc_qidx_pre", QIdx, 1);
        chk("rc_eqen_pre", EqEnable, 1);
        #2 Reset = 1'b1;
        #1;
        chk_all_zero("rc");
        @(negedge Clock);
        Reset = 1'b0;
        step();
        chk("rc_load", NewQ, 1);
        step();
        for (int k = 0; k < 3; k++) begin
            step();
            chk("rc_held_corr", Correct, 0);
            chk("rc_held_wait", EqEnable, 1);
        end
        chk("rc_held_score", Score, 0);
        Go = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
